// File: rtl/bit_serializer_pkg.sv
// Shared types and constants for the bit_serializer parallel-to-serial front end.
package bit_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEF_WIDTH    = 8;
  localparam bit DEF_IDLE_BIT = 1'b0;

  // Bit counter width; never below one bit so WIDTH=2 still has a counter.
  function automatic int cntWidth(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// Word-in / bit-out bus of the serializer: valid/ready word input plus serial output and status.
interface bit_serializer_if
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic             busy;

  modport master (
    output din, din_valid,
    input  din_ready, sout, sout_valid, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, sout, sout_valid, busy
  );

endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial shifter with a one-word holding register so consecutive words stream gap-free.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = DEF_IDLE_BIT
) (
  input  logic             clk,
  input  logic             rst,
  bit_serializer_if.slave  io_bus
);

  localparam int             CW   = cntWidth(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           r_state,    w_stateNext;
  logic [WIDTH-1:0] r_shreg,    w_shregNext;
  logic [WIDTH-1:0] r_hold,     w_holdNext;
  logic [CW-1:0]    r_bitcnt,   w_bitcntNext;
  logic             r_holdFull, w_holdFullNext;
  logic             w_xfer;
  logic             w_loadSlot;

  assign w_xfer     = io_bus.din_valid && !r_holdFull;
  assign w_loadSlot = (r_state == IDLE) || (r_bitcnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_shreg    <= '0;
      r_hold     <= '0;
      r_bitcnt   <= '0;
      r_holdFull <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_shreg    <= w_shregNext;
      r_hold     <= w_holdNext;
      r_bitcnt   <= w_bitcntNext;
      r_holdFull <= w_holdFullNext;
    end
  end

  // A held word always wins the load slot; otherwise an incoming word bypasses hold.
  always_comb begin
    w_stateNext    = r_state;
    w_shregNext    = r_shreg;
    w_holdNext     = r_hold;
    w_bitcntNext   = r_bitcnt;
    w_holdFullNext = r_holdFull;

    if (w_loadSlot) begin
      w_bitcntNext = '0;
      if (r_holdFull) begin
        w_shregNext    = r_hold;
        w_holdFullNext = 1'b0;
        w_stateNext    = SHIFT;
      end else if (w_xfer) begin
        w_shregNext = io_bus.din;
        w_stateNext = SHIFT;
      end else begin
        w_stateNext = IDLE;
      end
    end else begin
      if (MSB_FIRST) begin
        w_shregNext = {r_shreg[WIDTH-2:0], 1'b0};
      end else begin
        w_shregNext = {1'b0, r_shreg[WIDTH-1:1]};
      end
      w_bitcntNext = r_bitcnt + CW'(1);
    end

    if (w_xfer && !w_loadSlot) begin
      w_holdNext     = io_bus.din;
      w_holdFullNext = 1'b1;
    end
  end

  assign io_bus.din_ready  = !r_holdFull;
  assign io_bus.sout_valid = (r_state == SHIFT);
  assign io_bus.busy       = (r_state == SHIFT) || r_holdFull;
  assign io_bus.sout       = (r_state == SHIFT)
                             ? (MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0])
                             : IDLE_BIT;

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench: two serializers (MSB-first/idle 0 and LSB-first/idle 1) share one stimulus stream.
module tb_bit_serializer;
  import bit_serializer_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  bit_serializer_if #(.WIDTH(W)) ifA ();
  bit_serializer_if #(.WIDTH(W)) ifB ();

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dutA (
    .clk(clk), .rst(rst), .io_bus(ifA.slave)
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dutB (
    .clk(clk), .rst(rst), .io_bus(ifB.slave)
  );

  always #5 clk = ~clk;

  // Expected serial bit stream per DUT, in emission order.
  bit expQ [2][$];
  bit obsQ [$];
  bit capture = 1'b0;
  int compared   = 0;
  int mismatched = 0;

  task automatic compare(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, act, exp, $time);
    end
  endtask

  // The model: while bits are owed the DUT must be streaming them; ready only while at most one word is owed.
  task automatic checkOutput(input int d, input logic sv, input logic so, input logic rdy, input logic bz);
    int  n;
    bit  expValid;
    bit  expSout;
    n        = expQ[d].size();
    expValid = (n > 0);
    expSout  = expValid ? expQ[d][0] : (d == 1);
    compare("sout_valid", d, {31'd0, sv},  {31'd0, expValid});
    compare("sout",       d, {31'd0, so},  {31'd0, expSout});
    compare("din_ready",  d, {31'd0, rdy}, {31'd0, (n <= W)});
    compare("busy",       d, {31'd0, bz},  {31'd0, expValid});
    if (d == 0 && capture && sv === 1'b1) obsQ.push_back(so);
    if (expValid) void'(expQ[d].pop_front());
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      checkOutput(0, ifA.sout_valid, ifA.sout, ifA.din_ready, ifA.busy);
      checkOutput(1, ifB.sout_valid, ifB.sout, ifB.din_ready, ifB.busy);
    end
  end

  task automatic pushWord(input int d, input logic [W-1:0] w);
    for (int i = 0; i < W; i++) begin
      if (d == 0) expQ[d].push_back(w[W-1-i]);
      else        expQ[d].push_back(w[i]);
    end
  endtask

  // Drives one cycle of input after the monitor has sampled; ready is registered so it is stable here.
  task automatic applyStimulus(input logic [W-1:0] w, input logic v, output bit accepted);
    @(negedge clk);
    #2;
    ifA.din = w;  ifA.din_valid = v;
    ifB.din = w;  ifB.din_valid = v;
    accepted = v && (ifA.din_ready === 1'b1);
    if (v && ifA.din_ready === 1'b1) pushWord(0, w);
    if (v && ifB.din_ready === 1'b1) pushWord(1, w);
  endtask

  task automatic sendWord(input logic [W-1:0] w);
    bit acc;
    int tries;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 4 * W) begin
      applyStimulus(w, 1'b1, acc);
      tries++;
    end
    if (!acc) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL accept_timeout: word %0h never accepted (required acceptance within %0d cycles)", w, 4 * W);
    end
  endtask

  task automatic idleCycles(input int n);
    bit acc;
    repeat (n) applyStimulus('0, 1'b0, acc);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((expQ[0].size() != 0 || expQ[1].size() != 0) && t < 100) begin
      idleCycles(1);
      t++;
    end
    idleCycles(2);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit              acc;
    logic [15:0]     stream;
    logic [16:0]     hits;

    ifA.din = '0;  ifA.din_valid = 1'b0;
    ifB.din = '0;  ifB.din_valid = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    checkOutput(0, ifA.sout_valid, ifA.sout, ifA.din_ready, ifA.busy);
    checkOutput(1, ifB.sout_valid, ifB.sout, ifB.din_ready, ifB.busy);
    #2 rst = 1'b0;

    idleCycles(3);
    sendWord(8'hA5);
    drain();

    // Back-to-back pair: the stream must read 0000101010100000 with no gap.
    obsQ.delete();
    capture = 1'b1;
    sendWord(8'h0A);
    sendWord(8'hA0);
    drain();
    capture = 1'b0;
    compare("stream_len", 0, obsQ.size(), 16);
    stream = '0;
    for (int i = 0; i < 16 && i < obsQ.size(); i++) stream[15-i] = obsQ[i];
    compare("stream_bits", 0, {16'd0, stream}, 32'h0000_0AA0);
    hits = '0;
    for (int i = 3; i < 16 && i < obsQ.size(); i++) begin
      if (obsQ[i-3] && !obsQ[i-2] && obsQ[i-1] && !obsQ[i]) hits[i+1] = 1'b1;
    end
    compare("detect_pos", 0, {15'd0, hits}, (32'd1 << 8) | (32'd1 << 10) | (32'd1 << 12));

    sendWord(8'h11);
    sendWord(8'h22);
    sendWord(8'h33);
    drain();

    repeat (400) applyStimulus(W'($urandom), ($urandom_range(0, 3) != 0), acc);
    drain();

    // Asynchronous reset while bit 4 of 8'hFF is on the line and 8'hC3 sits in hold.
    sendWord(8'hFF);
    sendWord(8'hC3);
    idleCycles(3);
    #1 rst = 1'b1;
    expQ[0].delete();
    expQ[1].delete();
    #1;
    checkOutput(0, ifA.sout_valid, ifA.sout, ifA.din_ready, ifA.busy);
    checkOutput(1, ifB.sout_valid, ifB.sout, ifB.din_ready, ifB.busy);
    @(negedge clk);
    #3 rst = 1'b0;
    idleCycles(12);

    sendWord(8'h5C);
    repeat (60) applyStimulus(W'($urandom), ($urandom_range(0, 1) != 0), acc);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
